// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the memory-port arbiter. These are the
//                FSM state encoding, the requester identifiers and the default
//                widths.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 256;
    localparam int DEF_TMO_MAX = 255;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational winner select between the I-cache (req 0) and
//                D-cache (req 1) engines.
//                Build option MEM_ARB_RR_EN:
//                  defined   -> round-robin. A tie goes to the requester that
//                               did not win last time.
//                  undefined -> fixed priority. The D-cache wins every tie and
//                               last_grant_i is ignored.
//  Ports       : r0_en_i      req0 enable
//                r1_en_i      req1 enable
//                last_grant_i requester granted most recently
//                valid_o      at least one requester is asking
//                winner_o     selected requester (meaningful when valid_o)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic r0_en_i,
    input  logic r1_en_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    assign valid_o = r0_en_i | r1_en_i;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        winner_o = REQ_ICACHE;
        if (r0_en_i && r1_en_i) begin
            winner_o = ~last_grant_i;
        end else if (r1_en_i) begin
            winner_o = REQ_DCACHE;
        end
    end
`else
    // Fixed priority. The result depends only on whether the D-cache asks.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign winner_o = r1_en_i ? REQ_DCACHE : REQ_ICACHE;
`endif

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single 256-bit Data_Memory port between the
//                I-cache (req 0) and D-cache (req 1) miss/write-back engines.
//                One requester is granted at a time. Its command is registered
//                toward memory and held until mem_ack_i arrives. The ack and
//                the read line are then returned to the owner as a one-cycle
//                pulse.
//                Build option MEM_ARB_RR_EN selects round-robin arbitration
//                instead of fixed D-cache priority.
//  Ports       : clk_i, rst_i        clock / synchronous active-high reset
//                rN_enable_i         request, held until rN_ack_o
//                rN_write_i          1 = write line, 0 = read line
//                rN_addr_i/data_i    line address / write data
//                rN_ack_o/data_o     completion pulse / read data
//                mem_enable_o/write_o/addr_o/data_o   command to Data_Memory
//                mem_ack_i/data_i    response from Data_Memory
//                timeout_o           sticky, set when an ack takes TMO_MAX cycles
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_MAX = DEF_TMO_MAX
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              r0_enable_i,
    input  logic              r0_write_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_data_i,
    output logic              r0_ack_o,
    output logic [DATA_W-1:0] r0_data_o,

    input  logic              r1_enable_i,
    input  logic              r1_write_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_data_i,
    output logic              r1_ack_o,
    output logic [DATA_W-1:0] r1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              timeout_o
);

    localparam int                TMO_W   = $clog2(TMO_MAX + 1);
    localparam logic [TMO_W-1:0]  TMO_LIM = TMO_W'(TMO_MAX);

    arb_state_e        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              last_grant_q, last_grant_d;
    logic [TMO_W-1:0]  tmo_cnt_q,    tmo_cnt_d;
    logic              timeout_q,    timeout_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;
    logic              r0_ack_q,     r0_ack_d;
    logic              r1_ack_q,     r1_ack_d;
    logic [DATA_W-1:0] r0_data_q,    r0_data_d;
    logic [DATA_W-1:0] r1_data_q,    r1_data_d;

    logic              pick_valid;
    logic              pick_winner;

    mem_arb_pick u_pick (
        .r0_en_i      (r0_enable_i),
        .r1_en_i      (r1_enable_i),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        r0_ack_d     = 1'b0;           // acks are single-cycle pulses
        r1_ack_d     = 1'b0;
        r0_data_d    = r0_data_q;
        r1_data_d    = r1_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d      = pick_winner;
                    mem_enable_d = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = ST_BUSY;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = pick_winner;
`endif
                    if (pick_winner == REQ_DCACHE) begin
                        mem_write_d = r1_write_i;
                        mem_addr_d  = r1_addr_i;
                        mem_data_d  = r1_data_i;
                    end else begin
                        mem_write_d = r0_write_i;
                        mem_addr_d  = r0_addr_i;
                        mem_data_d  = r0_data_i;
                    end
                end
            end

            ST_BUSY: begin
                if (mem_ack_i) begin
                    mem_enable_d = 1'b0;
                    state_d      = ST_DONE;
                    if (owner_q == REQ_DCACHE) begin
                        r1_ack_d  = 1'b1;
                        r1_data_d = mem_data_i;
                    end else begin
                        r0_ack_d  = 1'b1;
                        r0_data_d = mem_data_i;
                    end
                end else begin
                    // Saturating wait counter. The transfer keeps waiting
                    // after the timeout flag is raised.
                    if (tmo_cnt_q != TMO_LIM) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    if (tmo_cnt_d == TMO_LIM) begin
                        timeout_d = 1'b1;
                    end
                end
            end

            // A grant is deliberately skipped here. The owner is only now
            // seeing its ack, so its enable may still be high and must not
            // start a second transfer.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_ICACHE;
            last_grant_q <= REQ_DCACHE;   // req0 wins the first round-robin tie
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_data_q    <= '0;
            r1_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            r0_data_q    <= r0_data_d;
            r1_data_q    <= r1_data_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign r0_ack_o     = r0_ack_q;
    assign r1_ack_o     = r1_ack_q;
    assign r0_data_o    = r0_data_q;
    assign r1_data_o    = r1_data_q;
    assign timeout_o    = timeout_q;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter. It
//                includes a behavioural Data_Memory with a 10-cycle ack
//                latency and 32-byte lines. A second instance with
//                TMO_MAX=8 and no memory exercises the timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_en, r0_wr, r1_en, r1_wr;
    logic [31:0]  r0_addr, r1_addr;
    logic [255:0] r0_wdata, r1_wdata;
    logic         r0_ack, r1_ack;
    logic [255:0] r0_rdata, r1_rdata;
    logic         mem_en, mem_wr, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         tmo;
    logic         inj_ack;

    logic         t_rst, t_r0_en;
    logic         t_zero1;
    logic [31:0]  t_zero32;
    logic [255:0] t_zero256;
    logic         t_r0_ack, t_r1_ack, t_mem_en, t_mem_wr, t_tmo;
    logic [255:0] t_r0_rdata, t_r1_rdata, t_mem_wdata;
    logic [31:0]  t_mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .r0_enable_i(r0_en), .r0_write_i(r0_wr), .r0_addr_i(r0_addr), .r0_data_i(r0_wdata),
        .r0_ack_o(r0_ack), .r0_data_o(r0_rdata),
        .r1_enable_i(r1_en), .r1_write_i(r1_wr), .r1_addr_i(r1_addr), .r1_data_i(r1_wdata),
        .r1_ack_o(r1_ack), .r1_data_o(r1_rdata),
        .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_ack_i(mem_ack | inj_ack), .mem_data_i(mem_rdata),
        .timeout_o(tmo)
    );

    mem_port_arbiter #(.TMO_MAX(8)) dut_t (
        .clk_i(clk), .rst_i(t_rst),
        .r0_enable_i(t_r0_en), .r0_write_i(t_zero1), .r0_addr_i(t_zero32), .r0_data_i(t_zero256),
        .r0_ack_o(t_r0_ack), .r0_data_o(t_r0_rdata),
        .r1_enable_i(t_zero1), .r1_write_i(t_zero1), .r1_addr_i(t_zero32), .r1_data_i(t_zero256),
        .r1_ack_o(t_r1_ack), .r1_data_o(t_r1_rdata),
        .mem_enable_o(t_mem_en), .mem_write_o(t_mem_wr), .mem_addr_o(t_mem_addr), .mem_data_o(t_mem_wdata),
        .mem_ack_i(t_zero1), .mem_data_i(t_zero256),
        .timeout_o(t_tmo)
    );

    // ---------------- Data_Memory model ----------------
    function automatic logic [255:0] line_init(input int i);
        return {8{32'h1111_0000 + 32'(i)}};
    endfunction

    logic [255:0] mem [64];
    int           m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= line_init(i);
            m_cnt   <= 0;
            mem_ack <= 1'b0;
        end else if (!mem_en || mem_ack) begin
            m_cnt   <= 0;
            mem_ack <= 1'b0;
        end else if (m_cnt == 9) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem[mem_addr[10:5]];
            if (mem_wr) mem[mem_addr[10:5]] <= mem_wdata;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- event monitors ----------------
    int   n_txn = 0, n_r0_ack = 0, n_r1_ack = 0;
    logic en_prev = 1'b0;

    always @(posedge clk) begin
        en_prev  <= mem_en;
        n_txn    <= n_txn + ((mem_en && !en_prev) ? 1 : 0);
        n_r0_ack <= n_r0_ack + (r0_ack ? 1 : 0);
        n_r1_ack <= n_r1_ack + (r1_ack ? 1 : 0);
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Called at the negedge where mem_enable_o was first seen high; returns
    // the number of negedges until the ack pulse is visible.
    task automatic wait_ack(input bit which, output int cyc);
        cyc = 0;
        while (((which ? r1_ack : r0_ack) !== 1'b1) && cyc < 40) begin
            tick();
            cyc++;
        end
        chk(which ? "r1_ack_seen" : "r0_ack_seen", which ? r1_ack : r0_ack, 1'b1);
    endtask

    int cyc, base_txn, base_ack;
    bit first;
    logic [31:0] a_first, a_second;

    initial begin
        rst = 1'b1; t_rst = 1'b1; inj_ack = 1'b0;
        r0_en = 0; r0_wr = 0; r0_addr = '0; r0_wdata = '0;
        r1_en = 0; r1_wr = 0; r1_addr = '0; r1_wdata = '0;
        t_r0_en = 0; t_zero1 = 0; t_zero32 = '0; t_zero256 = '0;
        tick(2);

        // Reset state
        chk("rst_mem_en",  mem_en,   1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_r0_ack",  r0_ack,   1'b0);
        chk("rst_r1_ack",  r1_ack,   1'b0);
        chk("rst_r0_data", r0_rdata, 256'h0);
        chk("rst_tmo",     tmo,      1'b0);
        rst = 1'b0;

        // 1: r0 read of line 32 alone
        r0_en = 1; r0_wr = 0; r0_addr = 32'h0000_0400;
        tick();
        chk("t1_mem_en",   mem_en,   1'b1);
        chk("t1_mem_wr",   mem_wr,   1'b0);
        chk("t1_mem_addr", mem_addr, 32'h0000_0400);
        wait_ack(0, cyc);
        chk("t1_latency",  cyc,      11);
        chk("t1_r0_data",  r0_rdata, line_init(32));
        chk("t1_r1_ack",   r1_ack,   1'b0);
        chk("t1_en_drop",  mem_en,   1'b0);
        r0_en = 0;
        tick();
        chk("t1_pulse_end", r0_ack,  1'b0);

        // 2: r1 write of 0xA5 to line 1
        r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_0020; r1_wdata = 256'hA5;
        tick();
        chk("t2_mem_wr",   mem_wr,    1'b1);
        chk("t2_mem_data", mem_wdata, 256'hA5);
        wait_ack(1, cyc);
        chk("t2_r0_ack",   r0_ack,    1'b0);
        chk("t2_r0_hold",  r0_rdata,  line_init(32));
        r1_en = 0; r1_wr = 0;
        tick(2);
        chk("t2_mem_line1", mem[1],   256'hA5);

        // mem_ack outside BUSY is ignored
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        tick();
        chk("inj_r0_ack", r0_ack, 1'b0);
        chk("inj_r1_ack", r1_ack, 1'b0);
        chk("inj_mem_en", mem_en, 1'b0);

        // 3: simultaneous requests, both held
        r0_en = 1; r0_addr = 32'h0000_0060;
        r1_en = 1; r1_addr = 32'h0000_0080;
        first    = RR ? 1'b0 : 1'b1;
        a_first  = first ? 32'h0000_0080 : 32'h0000_0060;
        a_second = first ? 32'h0000_0060 : 32'h0000_0080;
        tick();
        chk("t3_first_addr", mem_addr, a_first);
        wait_ack(first, cyc);
        chk("t3_first_data", first ? r1_rdata : r0_rdata, line_init(first ? 4 : 3));
        if (first) r1_en = 0; else r0_en = 0;
        tick();
        chk("t3_gap_en", mem_en, 1'b0);
        tick();
        chk("t3_second_en",   mem_en,   1'b1);
        chk("t3_second_addr", mem_addr, a_second);
        wait_ack(!first, cyc);
        chk("t3_second_data", first ? r0_rdata : r1_rdata, line_init(first ? 3 : 4));
        r0_en = 0; r1_en = 0;
        tick(2);

        // 4: r1 keeps enable through DONE, then drops -> one transaction
        base_txn = n_txn; base_ack = n_r1_ack;
        r1_en = 1; r1_addr = 32'h0000_00A0;
        tick();
        chk("t4_mem_en", mem_en, 1'b1);
        wait_ack(1, cyc);
        chk("t4_r1_data", r1_rdata, line_init(5));
        tick();
        r1_en = 0;
        tick(4);
        chk("t4_no_regrant", mem_en, 1'b0);
        chk("t4_txn_count",  n_txn - base_txn, 1);
        chk("t4_ack_count",  n_r1_ack - base_ack, 1);

        // 5: reset during BUSY cycle 5, then a fresh request
        r0_en = 1; r0_addr = 32'h0000_00C0;
        tick();
        chk("t5_mem_en", mem_en, 1'b1);
        tick(4);
        rst = 1; r0_en = 0;
        base_ack = n_r0_ack;
        tick();
        chk("t5_abort_en", mem_en, 1'b0);
        rst = 0;
        tick(15);
        chk("t5_no_ack", n_r0_ack - base_ack, 0);
        chk("t5_idle_en", mem_en, 1'b0);
        r0_en = 1; r0_addr = 32'h0000_0040;
        tick();
        chk("t5_new_addr", mem_addr, 32'h0000_0040);
        wait_ack(0, cyc);
        chk("t5_latency", cyc, 11);
        chk("t5_r0_data", r0_rdata, line_init(2));
        r0_en = 0;
        tick(2);
        chk("main_tmo_clear", tmo, 1'b0);

        // 6: TMO_MAX=8 instance, memory never acks
        t_rst = 0;
        tick();
        t_r0_en = 1;
        tick();
        chk("t6_mem_en", t_mem_en, 1'b1);
        tick(7);
        chk("t6_tmo_before", t_tmo, 1'b0);
        tick();
        chk("t6_tmo_set", t_tmo, 1'b1);
        t_r0_en = 0;
        tick(20);
        chk("t6_tmo_sticky", t_tmo, 1'b1);
        chk("t6_en_held",    t_mem_en, 1'b1);
        chk("t6_no_ack",     t_r0_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
